// File: rtl/psram_qpi_ctrl.sv
// QPI PSRAM controller: power-up sequence (delay, RSTEN/RST/QPI-enable in SPI) then QPI read/write bursts.
// Optional PSRAM_INIT_SKIP_EN shortens the power-up delay to 16 mem_clk cycles for fast simulation.
module psram_qpi_ctrl #(
    parameter int          INIT_CYCLES = 12800,
    parameter int          DATA_W      = 16,
    parameter int          BURST_WORDS = 1,
    parameter int          WAIT_CYCLES = 6,
    parameter logic [7:0]  CMD_READ    = 8'hEB,
    parameter logic [7:0]  CMD_WRITE   = 8'h38
) (
    input  logic              mem_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [23:0]       cmd_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              init_done,
    output logic              busy,
    output logic              mem_ce_n,
    output logic              mem_sclk,
    output logic [3:0]        mem_sio_o,
    output logic [3:0]        mem_sio_oe,
    input  logic [3:0]        mem_sio_i
);

    localparam int N = DATA_W / 4;
`ifdef PSRAM_INIT_SKIP_EN
    localparam int DELAY_LEN = 16;
`else
    localparam int DELAY_LEN = INIT_CYCLES;
`endif
    localparam int CNT_MAX0 = (DELAY_LEN > WAIT_CYCLES) ? DELAY_LEN : WAIT_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > 8) ? CNT_MAX0 : 8;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int NIB_W    = (N > 1) ? $clog2(N) : 1;
    localparam int WRD_W    = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

    typedef enum logic [3:0] {
        S_DELAY, S_RSTEN, S_RST, S_QPIEN, S_IDLE,
        S_CMD, S_ADDR, S_WAIT, S_DATA, S_END
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_lat_q, start_lat_d;
    logic               init_done_q, init_done_d;
    logic               ce_n_q, ce_n_d;
    logic               sclk_q, sclk_d;
    logic [3:0]         sio_o_q, sio_o_d;
    logic [3:0]         sio_oe_q, sio_oe_d;
    logic               wr_req_q, wr_req_d;
    logic               rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               we_q, we_d;
    logic [NIB_W-1:0]   nib_cnt_q, nib_cnt_d;
    logic [WRD_W-1:0]   wrd_cnt_q, wrd_cnt_d;
    logic [31:0]        tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]  wr_sh_q, wr_sh_d;
    logic [DATA_W-1:0]  nxt_word_q, nxt_word_d;
    logic [DATA_W-1:0]  rd_sh_q, rd_sh_d;
    logic [7:0]         opc;
    logic [7:0]         spi_op;
    logic               fall, rise;
    logic               last_nib, last_word;

    function automatic logic [7:0] next_spi_op(input state_t s);
        case (s)
            S_DELAY: next_spi_op = 8'h66;
            S_RSTEN: next_spi_op = 8'h99;
            S_RST:   next_spi_op = 8'h35;
            default: next_spi_op = 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] top_nib(input logic [DATA_W-1:0] w);
        top_nib = w[DATA_W-1 -: 4];
    endfunction

    // fall/rise name the SCLK transition the coming mem_clk edge produces
    assign fall      = !ce_n_q && sclk_q;
    assign rise      = !ce_n_q && !sclk_q;
    assign last_nib  = (nib_cnt_q == NIB_W'(N - 1));
    assign last_word = (wrd_cnt_q == WRD_W'(BURST_WORDS - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_lat_d = start_lat_q;
        init_done_d = init_done_q;
        ce_n_d      = ce_n_q;
        sclk_d      = 1'b0;
        sio_o_d     = sio_o_q;
        sio_oe_d    = sio_oe_q;
        wr_req_d    = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        we_d        = we_q;
        nib_cnt_d   = nib_cnt_q;
        wrd_cnt_d   = wrd_cnt_q;
        tx_sh_d     = tx_sh_q;
        wr_sh_d     = wr_sh_q;
        rd_sh_d     = rd_sh_q;
        nxt_word_d  = wr_req_q ? wr_data : nxt_word_q;
        opc         = cmd_we ? CMD_WRITE : CMD_READ;
        spi_op      = next_spi_op(state_q);
        if (!ce_n_q) sclk_d = ~sclk_q;

        case (state_q)
            S_DELAY: begin
                start_lat_d = start_lat_q | start;
                if (start_lat_q) begin
                    if (cnt_q == CNT_W'(DELAY_LEN - 1)) begin
                        state_d  = S_RSTEN;
                        cnt_d    = '0;
                        ce_n_d   = 1'b0;
                        tx_sh_d  = {spi_op, 24'h0};
                        sio_o_d  = {3'b000, spi_op[7]};
                        sio_oe_d = 4'b0001;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // SPI opcode window (CE low) followed by a 4-cycle CE-high gap in the same state
            S_RSTEN, S_RST, S_QPIEN: begin
                if (!ce_n_q) begin
                    if (fall) begin
                        if (cnt_q == CNT_W'(7)) begin
                            ce_n_d   = 1'b1;
                            sio_o_d  = 4'h0;
                            sio_oe_d = 4'h0;
                            cnt_d    = '0;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            tx_sh_d = tx_sh_q << 1;
                            sio_o_d = {3'b000, tx_sh_q[30]};
                        end
                    end
                end else if (cnt_q == CNT_W'(3)) begin
                    cnt_d = '0;
                    if (state_q == S_QPIEN) begin
                        state_d     = S_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        state_d  = (state_q == S_RSTEN) ? S_RST : S_QPIEN;
                        ce_n_d   = 1'b0;
                        tx_sh_d  = {spi_op, 24'h0};
                        sio_o_d  = {3'b000, spi_op[7]};
                        sio_oe_d = 4'b0001;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_IDLE: begin
                if (cmd_valid && init_done_q) begin
                    state_d  = S_CMD;
                    cnt_d    = '0;
                    we_d     = cmd_we;
                    tx_sh_d  = {opc, cmd_addr};
                    wr_sh_d  = wr_data;
                    ce_n_d   = 1'b0;
                    sio_o_d  = opc[7:4];
                    sio_oe_d = 4'hF;
                end
            end

            S_CMD: begin
                if (fall) begin
                    tx_sh_d = tx_sh_q << 4;
                    sio_o_d = tx_sh_q[27:24];
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_ADDR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_ADDR: begin
                if (fall) begin
                    if (cnt_q == CNT_W'(5)) begin
                        cnt_d     = '0;
                        nib_cnt_d = '0;
                        wrd_cnt_d = '0;
                        if (we_q) begin
                            state_d  = S_DATA;
                            sio_o_d  = top_nib(wr_sh_q);
                            wr_sh_d  = wr_sh_q << 4;
                            wr_req_d = (N == 1) && (BURST_WORDS > 1);
                        end else begin
                            state_d  = (WAIT_CYCLES > 0) ? S_WAIT : S_DATA;
                            sio_o_d  = 4'h0;
                            sio_oe_d = 4'h0;
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        tx_sh_d = tx_sh_q << 4;
                        sio_o_d = tx_sh_q[27:24];
                    end
                end
            end

            S_WAIT: begin
                if (fall) begin
                    if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (rise && !we_q) begin
                    rd_sh_d = (rd_sh_q << 4) | DATA_W'(mem_sio_i);
                    if (last_nib) begin
                        rd_data_d  = (rd_sh_q << 4) | DATA_W'(mem_sio_i);
                        rd_valid_d = 1'b1;
                    end
                end
                if (fall) begin
                    if (last_nib && last_word) begin
                        state_d  = S_END;
                        cnt_d    = '0;
                        ce_n_d   = 1'b1;
                        sio_o_d  = 4'h0;
                        sio_oe_d = 4'h0;
                    end else if (last_nib) begin
                        nib_cnt_d = '0;
                        wrd_cnt_d = wrd_cnt_q + 1'b1;
                        if (we_q) begin
                            sio_o_d  = top_nib(nxt_word_q);
                            wr_sh_d  = nxt_word_q << 4;
                            wr_req_d = (N == 1) && (int'(wrd_cnt_q) + 1 < BURST_WORDS - 1);
                        end
                    end else begin
                        nib_cnt_d = nib_cnt_q + 1'b1;
                        if (we_q) begin
                            sio_o_d  = top_nib(wr_sh_q);
                            wr_sh_d  = wr_sh_q << 4;
                            // request the next word while its predecessor's last nibble goes out
                            wr_req_d = (int'(nib_cnt_q) + 1 == N - 1) && !last_word;
                        end
                    end
                end
            end

            S_END: begin
                if (cnt_q == CNT_W'(3)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = S_DELAY;
        endcase
    end

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q     <= S_DELAY;
            cnt_q       <= '0;
            start_lat_q <= 1'b0;
            init_done_q <= 1'b0;
            ce_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            sio_o_q     <= 4'h0;
            sio_oe_q    <= 4'h0;
            wr_req_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            we_q        <= 1'b0;
            nib_cnt_q   <= '0;
            wrd_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_lat_q <= start_lat_d;
            init_done_q <= init_done_d;
            ce_n_q      <= ce_n_d;
            sclk_q      <= sclk_d;
            sio_o_q     <= sio_o_d;
            sio_oe_q    <= sio_oe_d;
            wr_req_q    <= wr_req_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            we_q        <= we_d;
            nib_cnt_q   <= nib_cnt_d;
            wrd_cnt_q   <= wrd_cnt_d;
        end
    end

    always_ff @(posedge mem_clk) begin
        tx_sh_q    <= tx_sh_d;
        wr_sh_q    <= wr_sh_d;
        nxt_word_q <= nxt_word_d;
        rd_sh_q    <= rd_sh_d;
    end

    assign cmd_ready  = (state_q == S_IDLE) && init_done_q;
    assign busy       = (state_q != S_IDLE);
    assign init_done  = init_done_q;
    assign wr_req     = wr_req_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign mem_ce_n   = ce_n_q;
    assign mem_sclk   = sclk_q;
    assign mem_sio_o  = sio_o_q;
    assign mem_sio_oe = sio_oe_q;

endmodule

// File: tb/tb_psram_qpi_ctrl.sv
// Directed bench for psram_qpi_ctrl: init sequence, write/read bursts, handshake gating, mid-burst reset.
module tb_psram_qpi_ctrl;

    localparam int DW = 16;

    logic          mem_clk;
    logic          rst;
    logic          start;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [23:0]   cmd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_req;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          init_done;
    logic          busy;
    logic          mem_ce_n;
    logic          mem_sclk;
    logic [3:0]    mem_sio_o;
    logic [3:0]    mem_sio_oe;
    logic [3:0]    mem_sio_i;

    psram_qpi_ctrl #(
        .INIT_CYCLES (16),
        .DATA_W      (DW),
        .BURST_WORDS (2),
        .WAIT_CYCLES (6),
        .CMD_READ    (8'hEB),
        .CMD_WRITE   (8'h38)
    ) dut (
        .mem_clk    (mem_clk),
        .rst        (rst),
        .start      (start),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .wr_data    (wr_data),
        .wr_req     (wr_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .init_done  (init_done),
        .busy       (busy),
        .mem_ce_n   (mem_ce_n),
        .mem_sclk   (mem_sclk),
        .mem_sio_o  (mem_sio_o),
        .mem_sio_oe (mem_sio_oe),
        .mem_sio_i  (mem_sio_i)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;
    int early_ready = 0;

    logic [3:0]    drive_tab [0:63];
    logic [3:0]    nib_a     [0:63];
    logic [3:0]    oe_a      [0:63];
    logic [DW-1:0] rdw       [0:7];
    int            rdv_cnt, wrq_cnt, wrq_cyc;
    logic [DW-1:0] wr_next;

    task automatic tick();
        if (cmd_valid && cmd_ready) hs_cnt++;
        @(posedge mem_clk);
        #1;
        if (cmd_ready && !init_done) early_ready++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Capture one CE-low window; a small memory model answers from drive_tab by SCLK index.
    task automatic window(output int ncyc, output int nsclk, output int ok);
        int g;
        g = 0;
        ok = 1;
        ncyc = 0;
        nsclk = 0;
        rdv_cnt = 0;
        wrq_cnt = 0;
        wrq_cyc = -1;
        while (mem_ce_n && g < 300) begin
            tick();
            g++;
        end
        if (mem_ce_n) begin
            ok = 0;
            return;
        end
        while (!mem_ce_n && ncyc < 200) begin
            if (mem_sclk) begin
                if (nsclk < 64) begin
                    nib_a[nsclk] = mem_sio_o;
                    oe_a[nsclk]  = mem_sio_oe;
                end
                nsclk++;
            end else begin
                mem_sio_i = (nsclk < 64) ? drive_tab[nsclk] : 4'h0;
            end
            if (wr_req) begin
                wrq_cnt++;
                wrq_cyc = ncyc;
                wr_data = wr_next;
            end
            if (rd_valid) begin
                if (rdv_cnt < 8) rdw[rdv_cnt] = rd_data;
                rdv_cnt++;
            end
            ncyc++;
            tick();
        end
        if (!mem_ce_n) ok = 0;
    endtask

    task automatic gap(output int n);
        n = 0;
        while (mem_ce_n && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic idle_wait(output int n);
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_init(input string pfx);
        logic [7:0] exp_op [0:2];
        logic [7:0] b;
        int n, s, ok, g, bad;
        exp_op[0] = 8'h66;
        exp_op[1] = 8'h99;
        exp_op[2] = 8'h35;
        for (int w = 0; w < 3; w++) begin
            window(n, s, ok);
            chk({pfx, "_win_ok"}, 64'(ok), 64'd1);
            chk({pfx, "_win_cycles"}, 64'(n), 64'd16);
            b = '0;
            bad = 0;
            for (int i = 0; i < 8; i++) begin
                b = {b[6:0], nib_a[i][0]};
                if (oe_a[i] !== 4'b0001) bad++;
            end
            chk({pfx, "_spi_byte"}, 64'(b), 64'(exp_op[w]));
            chk({pfx, "_spi_oe"}, 64'(bad), 64'd0);
            chk({pfx, "_no_done_yet"}, 64'(init_done), 64'd0);
            if (w < 2) begin
                gap(g);
                chk({pfx, "_ce_gap"}, 64'(g), 64'd4);
            end
        end
    endtask

    initial begin
        int n, s, ok, bad, lows;
        logic [63:0] got;

        rst = 1'b1;
        start = 1'b0;
        cmd_valid = 1'b0;
        cmd_we = 1'b0;
        cmd_addr = 24'h0;
        wr_data = '0;
        wr_next = '0;
        mem_sio_i = 4'h0;
        for (int i = 0; i < 64; i++) drive_tab[i] = 4'h0;
        repeat (3) tick();

        chk("rst_ce_n", 64'(mem_ce_n), 64'd1);
        chk("rst_sclk", 64'(mem_sclk), 64'd0);
        chk("rst_oe", 64'(mem_sio_oe), 64'd0);
        chk("rst_sio_o", 64'(mem_sio_o), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_rd", 64'({rd_valid, rd_data, wr_req}), 64'd0);

        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!mem_ce_n) lows++;
        end
        chk("idle_without_start", 64'(lows), 64'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        gap(n);
        chk("init_delay", 64'(n), 64'd16);
        run_init("init1");
        n = 0;
        while (!init_done && n < 50) begin
            tick();
            n++;
        end
        chk("init_done_after_gap", 64'(n), 64'd4);
        chk("ready_after_init", 64'(cmd_ready), 64'd1);
        chk("busy_after_init", 64'(busy), 64'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!mem_ce_n) lows++;
        end
        chk("start_after_init_ignored", 64'(lows), 64'd0);
        chk("start_after_init_done", 64'(init_done), 64'd1);

        hs_cnt = 0;
        cmd_we = 1'b1;
        cmd_addr = 24'h123456;
        wr_data = 16'hBEEF;
        wr_next = 16'hCAFE;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wr_data = 16'h0000;
        window(n, s, ok);
        chk("wr_win_ok", 64'(ok), 64'd1);
        chk("wr_ce_cycles", 64'(n), 64'd32);
        chk("wr_sclks", 64'(s), 64'd16);
        got = '0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            got = {got[59:0], nib_a[i]};
            if (oe_a[i] !== 4'hF) bad++;
        end
        chk("wr_nibbles", got, 64'h3812_3456_BEEF_CAFE);
        chk("wr_oe", 64'(bad), 64'd0);
        chk("wr_req_count", 64'(wrq_cnt), 64'd1);
        chk("wr_req_cycle", 64'(wrq_cyc), 64'd22);
        chk("wr_handshakes", 64'(hs_cnt), 64'd1);
        chk("wr_busy_end", 64'(busy), 64'd1);
        idle_wait(n);
        chk("wr_end_hold", 64'(n), 64'd4);

        drive_tab[14] = 4'hA;
        drive_tab[15] = 4'hB;
        drive_tab[16] = 4'hC;
        drive_tab[17] = 4'hD;
        drive_tab[18] = 4'h1;
        drive_tab[19] = 4'h2;
        drive_tab[20] = 4'h3;
        drive_tab[21] = 4'h4;
        cmd_we = 1'b0;
        cmd_addr = 24'h000010;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        window(n, s, ok);
        chk("rd_win_ok", 64'(ok), 64'd1);
        chk("rd_ce_cycles", 64'(n), 64'd44);
        got = '0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            got = {got[59:0], nib_a[i]};
            if (oe_a[i] !== 4'hF) bad++;
        end
        for (int i = 8; i < 22; i++) if (oe_a[i] !== 4'h0) bad++;
        chk("rd_cmd_addr", got, 64'hEB00_0010);
        chk("rd_oe", 64'(bad), 64'd0);
        chk("rd_valid_count", 64'(rdv_cnt), 64'd2);
        chk("rd_word0", 64'(rdw[0]), 64'hABCD);
        chk("rd_word1", 64'(rdw[1]), 64'h1234);
        idle_wait(n);
        chk("rd_end_hold", 64'(n), 64'd4);

        cmd_we = 1'b1;
        cmd_addr = 24'h123456;
        wr_data = 16'hBEEF;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 26; c++) begin
            if (wr_req) wr_data = 16'hCAFE;
            tick();
        end
        chk("mid_wr_active", 64'({mem_ce_n, mem_sio_o}), 64'h0A);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ce_n", 64'(mem_ce_n), 64'd1);
        chk("mid_rst_oe", 64'(mem_sio_oe), 64'd0);
        chk("mid_rst_init_done", 64'(init_done), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd1);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!mem_ce_n) lows++;
        end
        chk("mid_rst_quiet", 64'(lows), 64'd0);

        hs_cnt = 0;
        cmd_we = 1'b0;
        cmd_addr = 24'h000010;
        cmd_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_init("init2");
        window(n, s, ok);
        chk("held_rd_ok", 64'(ok), 64'd1);
        chk("held_rd_cycles", 64'(n), 64'd44);
        chk("held_rd_words", 64'({rdw[0], rdw[1]}), 64'hABCD_1234);
        cmd_valid = 1'b0;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!mem_ce_n) lows++;
        end
        chk("held_single_handshake", 64'(hs_cnt), 64'd1);
        chk("held_no_second_cmd", 64'(lows), 64'd0);
        chk("ready_only_after_init", 64'(early_ready), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
